// File: rtl/lm75a_i2c_reader.sv
// Purpose: periodic I2C master; reads the LM75A temperature register (current-pointer read) into a 16-bit word.
// Latency: 29 bit slots (116*QDIV clk) per poll; valid pulses 112*QDIV clk after START slot entry.
// Backpressure: none; data is a held register and a poll wrap that lands while busy is dropped.
module lm75a_i2c_reader #(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter int         QDIV        = 125,
    parameter int         POLL_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        scl,
    output logic [15:0] data,
    output logic        valid,
    output logic        busy,
    output logic        ack_err
);

    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [QW-1:0] Q_LAST    = QW'(QDIV - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    // Address phase byte: 7-bit slave address followed by R/W = 1 (read).
    localparam logic [7:0]    ADDR_BYTE = {DEV_ADDR, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_AACK,
        ST_RD_MSB,
        ST_MACK,
        ST_RD_LSB,
        ST_MNACK,
        ST_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [2:0]      bit_q, bit_d;
    // Only the bits that reach the output are kept: MSB[7:0] then LSB[7:5].
    logic [10:0]     rx_q, rx_d;
    logic            nack_q, nack_d;
    logic            scl_q, scl_d;
    logic            sda_oe_q, sda_oe_d;
    logic [15:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            ack_err_q, ack_err_d;

    logic            poll_wrap;
    logic            q_end;
    logic            slot_end;
    logic            sample_pt;

    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign ack_err = ack_err_q;

    // Free-running poll period counter; its wrap is the only trigger for a transaction.
    always_comb begin
        poll_wrap  = (poll_cnt_q == POLL_LAST);
        poll_cnt_d = poll_wrap ? '0 : poll_cnt_q + PW'(1);
    end

    // Quarter-period and bit-slot timing; held at slot start while idle so START begins at Q0.
    always_comb begin
        q_end     = (qcnt_q == Q_LAST);
        slot_end  = q_end && (quarter_q == 2'd3);
        // The slave's bit is taken on the last cycle of Q2, mid-way through SCL high.
        sample_pt = (state_q != ST_IDLE) && q_end && (quarter_q == 2'd2);
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        if (state_q == ST_IDLE) begin
            qcnt_d    = '0;
            quarter_d = 2'd0;
        end else if (q_end) begin
            qcnt_d    = '0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            qcnt_d    = qcnt_q + QW'(1);
        end
    end

    // Transaction sequencing, bit capture and result publication.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        rx_d      = rx_q;
        nack_d    = nack_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ack_err_d = ack_err_q;

        if (sample_pt) begin
            if (state_q == ST_AACK) begin
                nack_d = sda_in;
            end
            // LSB bits 4..0 are discarded, so shifting stops after LSB bit 5.
            if ((state_q == ST_RD_MSB) || ((state_q == ST_RD_LSB) && (bit_q <= 3'd2))) begin
                rx_d = {rx_q[9:0], sda_in};
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (poll_wrap) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    state_d = ST_ADDR;
                    bit_d   = 3'd0;
                end
            end
            ST_ADDR: begin
                if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_AACK;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ST_AACK: begin
                if (slot_end) begin
                    if (nack_q) begin
                        // No device answered: abandon the read, keep the old data.
                        state_d   = ST_STOP;
                        ack_err_d = 1'b1;
                    end else begin
                        state_d   = ST_RD_MSB;
                        bit_d     = 3'd0;
                    end
                end
            end
            ST_RD_MSB: begin
                if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_MACK;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ST_MACK: begin
                if (slot_end) begin
                    state_d = ST_RD_LSB;
                    bit_d   = 3'd0;
                end
            end
            ST_RD_LSB: begin
                if (slot_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_MNACK;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ST_MNACK: begin
                if (slot_end) begin
                    // Both bytes land in one update so the display never sees a mixed value.
                    state_d   = ST_STOP;
                    data_d    = {rx_q, 5'b0};
                    valid_d   = 1'b1;
                    ack_err_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (slot_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus pin levels for the next cycle, decoded from the next state so the pads are flop-driven.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
            ST_START: begin
                // SCL stays high; SDA falls at Q2 entry to form the START condition.
                scl_d    = 1'b1;
                sda_oe_d = quarter_d[1];
            end
            ST_ADDR: begin
                scl_d    = quarter_d[1];
                sda_oe_d = ~ADDR_BYTE[3'd7 - bit_d];
            end
            ST_MACK: begin
                scl_d    = quarter_d[1];
                sda_oe_d = 1'b1;
            end
            ST_STOP: begin
                // SDA held low until Q3 so its release with SCL high forms the STOP condition.
                scl_d    = quarter_d[1];
                sda_oe_d = (quarter_d != 2'd3);
            end
            default: begin
                // AACK, RD_MSB, RD_LSB, MNACK: SDA released for the slave or for a NACK.
                scl_d    = quarter_d[1];
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, shift register and output registers; reset releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_q <= '0;
            qcnt_q     <= '0;
            quarter_q  <= 2'd0;
            bit_q      <= 3'd0;
            rx_q       <= '0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            data_q     <= 16'h0000;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            qcnt_q     <= qcnt_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            rx_q       <= rx_d;
            nack_q     <= nack_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ack_err_q  <= ack_err_d;
        end
    end

endmodule

// File: tb/tb_lm75a_i2c_reader.sv
// Bench for lm75a_i2c_reader: behavioural LM75A slave plus bus monitor, directed scenarios.
// Latency: waits are bounded by cycle budgets derived from QDIV and POLL.
// Backpressure: not applicable; the slave answers on every SCL falling edge.
module tb_lm75a_i2c_reader;

    localparam int QDIV = 2;
    localparam int POLL = 400;
    localparam int SLOT = 4 * QDIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sda_oe;
    logic        scl;
    logic [15:0] data;
    logic        valid;
    logic        busy;
    logic        ack_err;

    // Slave-side controls, driven by the test tasks.
    logic [7:0]  slave_msb = 8'h00;
    logic [7:0]  slave_lsb = 8'h00;
    logic        ack_en    = 1'b1;

    // Monitor / slave state, written only by the monitor process.
    logic        slave_pull = 1'b0;
    logic        slave_acked = 1'b0;
    logic        scl_prev = 1'b1;
    logic        sda_prev = 1'b1;
    logic        in_xfer = 1'b0;
    logic        high_after_rise = 1'b0;
    logic        busy_prev = 1'b0;
    logic        valid_prev = 1'b0;
    logic [31:0] rx_bits = '0;
    int          n = 0;
    int          run_len = 0;
    int          bus_err = 0;
    int          low_bad = 0;
    int          high_bad = 0;
    int          low_seen = 0;
    int          high_seen = 0;
    int          idle_bad = 0;
    int          start_cnt = 0;
    int          stop_cnt = 0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          rise_cyc = 0;
    int          prev_rise_cyc = 0;
    int          fall_cyc = 0;
    int          valid_cnt = 0;
    int          valid_cyc = 0;
    int          valid_width_bad = 0;

    int          cyc = 0;
    int          rel_cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    wire sda_bus = !(sda_oe || slave_pull);

    lm75a_i2c_reader #(
        .DEV_ADDR    (7'h48),
        .QDIV        (QDIV),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .scl     (scl),
        .data    (data),
        .valid   (valid),
        .busy    (busy),
        .ack_err (ack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // What the LM75A puts on SDA after the SCL falling edge that follows rising edge k.
    function automatic logic slave_bit(input int k, input logic acked, input logic aen,
                                       input logic [7:0] m, input logic [7:0] l);
        logic r;
        r = 1'b0;
        if (k == 8) r = aen;
        else if (acked && k >= 9 && k <= 16) r = !m[3'(16 - k)];
        else if (acked && k >= 18 && k <= 25) r = !l[3'(25 - k)];
        return r;
    endfunction

    // Bus monitor and slave, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            slave_pull      <= 1'b0;
            slave_acked     <= 1'b0;
            scl_prev        <= 1'b1;
            sda_prev        <= 1'b1;
            in_xfer         <= 1'b0;
            high_after_rise <= 1'b0;
            busy_prev       <= 1'b0;
            valid_prev      <= 1'b0;
            n               <= 0;
            run_len         <= 0;
        end else begin
            busy_prev  <= busy;
            valid_prev <= valid;
            if (busy && !busy_prev) begin
                prev_rise_cyc <= rise_cyc;
                rise_cyc      <= cyc;
                rise_cnt      <= rise_cnt + 1;
            end
            if (!busy && busy_prev) begin
                fall_cyc <= cyc;
                fall_cnt <= fall_cnt + 1;
            end
            if (valid) begin
                valid_cnt <= valid_cnt + 1;
                valid_cyc <= cyc;
                if (valid_prev) valid_width_bad <= valid_width_bad + 1;
            end
            if (!busy && (!scl || sda_oe)) idle_bad <= idle_bad + 1;

            if (scl_prev && scl && (sda_bus != sda_prev)) begin
                if (!sda_bus) begin
                    if (in_xfer) bus_err <= bus_err + 1;
                    in_xfer         <= 1'b1;
                    n               <= 0;
                    start_cnt       <= start_cnt + 1;
                    high_after_rise <= 1'b0;
                    slave_acked     <= 1'b0;
                end else begin
                    if (!in_xfer || !((n == 28) || (n == 10 && rx_bits[9]))) bus_err <= bus_err + 1;
                    in_xfer  <= 1'b0;
                    stop_cnt <= stop_cnt + 1;
                end
            end

            if (scl != scl_prev) begin
                run_len <= 1;
                if (!scl_prev) begin
                    low_seen <= low_seen + 1;
                    if (run_len != 2 * QDIV) low_bad <= low_bad + 1;
                    n <= n + 1;
                    if (n < 31) rx_bits[n + 1] <= sda_bus;
                    high_after_rise <= 1'b1;
                end else begin
                    if (high_after_rise) begin
                        high_seen <= high_seen + 1;
                        if (run_len != 2 * QDIV) high_bad <= high_bad + 1;
                    end
                    slave_pull <= slave_bit(n, slave_acked, ack_en, slave_msb, slave_lsb);
                    if (n == 8) slave_acked <= ack_en;
                end
            end else begin
                run_len <= run_len + 1;
            end
            scl_prev <= scl;
            sda_prev <= sda_bus;
        end
    end

    task automatic wait_valid(input int budget, output bit ok);
        int snap = valid_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (valid_cnt != snap) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_busy_rise(input int budget, output bit ok);
        int snap = rise_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (rise_cnt != snap) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_busy_fall(input int budget, output bit ok);
        int snap = fall_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (fall_cnt != snap) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (scl !== 1'b1) begin miscompares++; $display("FAIL reset_scl: got %b want 1", scl); end
        vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
        vectors++; if (data !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h want 0000", data); end
        vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
        slave_msb = 8'h19;
        slave_lsb = 8'h80;
        ack_en    = 1'b1;
        rel_cyc   = cyc;
        rst_n     = 1'b1;
    endtask

    task automatic test_read_25_5();
        bit ok;
        int v0 = valid_cnt;
        logic [7:0] ab;
        wait_busy_rise(POLL + 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL read_start_timeout: got none want START"); end
        vectors++; if (rise_cyc - rel_cyc != POLL) begin miscompares++; $display("FAIL first_start_delay: got %0d want %0d", rise_cyc - rel_cyc, POLL); end
        wait_valid(SLOT * 30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL read_valid_timeout: got none want pulse"); end
        vectors++; if (data !== 16'h1980) begin miscompares++; $display("FAIL read_data: got %h want 1980", data); end
        vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL read_ack_err: got %b want 0", ack_err); end
        vectors++; if (valid_cyc - rise_cyc != 28 * SLOT) begin miscompares++; $display("FAIL valid_latency: got %0d want %0d", valid_cyc - rise_cyc, 28 * SLOT); end
        ab = 8'h00;
        for (int i = 1; i <= 8; i++) ab = {ab[6:0], rx_bits[i]};
        vectors++; if (ab !== 8'h91) begin miscompares++; $display("FAIL addr_byte: got %h want 91", ab); end
        vectors++; if (rx_bits[18] !== 1'b0) begin miscompares++; $display("FAIL master_ack: got %b want 0", rx_bits[18]); end
        vectors++; if (rx_bits[27] !== 1'b1) begin miscompares++; $display("FAIL master_nack: got %b want 1", rx_bits[27]); end
        wait_busy_fall(SLOT * 4, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL read_end_timeout: got none want busy fall"); end
        vectors++; if (fall_cyc - rise_cyc != 29 * SLOT) begin miscompares++; $display("FAIL busy_length: got %0d want %0d", fall_cyc - rise_cyc, 29 * SLOT); end
        vectors++; if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL read_valid_count: got %0d want 1", valid_cnt - v0); end
        vectors++; if (valid_width_bad != 0) begin miscompares++; $display("FAIL valid_width: got %0d long pulses want 0", valid_width_bad); end
    endtask

    task automatic test_lsb_mask_sign();
        bit ok;
        int v0 = valid_cnt;
        slave_msb = 8'h7D;
        slave_lsb = 8'hFF;
        wait_busy_rise(POLL + 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL mask_start_timeout: got none want START"); end
        vectors++; if (rise_cyc - prev_rise_cyc != POLL) begin miscompares++; $display("FAIL poll_spacing: got %0d want %0d", rise_cyc - prev_rise_cyc, POLL); end
        wait_valid(SLOT * 30, ok);
        vectors++; if (data !== 16'h7DE0) begin miscompares++; $display("FAIL mask_data: got %h want 7de0", data); end
        slave_msb = 8'hE7;
        slave_lsb = 8'h00;
        wait_valid(POLL + SLOT * 30, ok);
        vectors++; if (data !== 16'hE700) begin miscompares++; $display("FAIL sign_data: got %h want e700", data); end
        vectors++; if (valid_cnt - v0 != 2) begin miscompares++; $display("FAIL two_polls_valid: got %0d want 2", valid_cnt - v0); end
        wait_busy_fall(SLOT * 4, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sign_end_timeout: got none want busy fall"); end
    endtask

    task automatic test_addr_nack();
        bit ok;
        int v0 = valid_cnt;
        int s0 = stop_cnt;
        ack_en = 1'b0;
        wait_busy_rise(POLL + 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL nack_start_timeout: got none want START"); end
        wait_busy_fall(SLOT * 30, ok);
        vectors++; if (fall_cyc - rise_cyc != 11 * SLOT) begin miscompares++; $display("FAIL nack_length: got %0d want %0d", fall_cyc - rise_cyc, 11 * SLOT); end
        vectors++; if (ack_err !== 1'b1) begin miscompares++; $display("FAIL nack_ack_err: got %b want 1", ack_err); end
        vectors++; if (data !== 16'hE700) begin miscompares++; $display("FAIL nack_data_held: got %h want e700", data); end
        vectors++; if (valid_cnt != v0) begin miscompares++; $display("FAIL nack_valid: got %0d pulses want 0", valid_cnt - v0); end
        vectors++; if (stop_cnt - s0 != 1) begin miscompares++; $display("FAIL nack_stop: got %0d stops want 1", stop_cnt - s0); end
        ack_en    = 1'b1;
        slave_msb = 8'h00;
        slave_lsb = 8'h20;
        wait_busy_rise(POLL + 50, ok);
        vectors++; if (rise_cyc - prev_rise_cyc != POLL) begin miscompares++; $display("FAIL retry_spacing: got %0d want %0d", rise_cyc - prev_rise_cyc, POLL); end
        wait_valid(SLOT * 30, ok);
        vectors++; if (ack_err !== 1'b0) begin miscompares++; $display("FAIL retry_ack_err: got %b want 0", ack_err); end
        vectors++; if (data !== 16'h0020) begin miscompares++; $display("FAIL retry_data: got %h want 0020", data); end
        wait_busy_fall(SLOT * 4, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_busy_rise(POLL + 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL mid_start_timeout: got none want START"); end
        repeat (10 * SLOT + 1) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (scl !== 1'b1) begin miscompares++; $display("FAIL mid_reset_scl: got %b want 1", scl); end
        vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL mid_reset_sda_oe: got %b want 0", sda_oe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        vectors++; if (data !== 16'h0000) begin miscompares++; $display("FAIL mid_reset_data: got %h want 0000", data); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b want 0", valid); end
        repeat (3) @(negedge clk);
        rel_cyc = cyc;
        rst_n   = 1'b1;
        wait_busy_rise(POLL + 50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL restart_timeout: got none want START"); end
        vectors++; if (rise_cyc - rel_cyc != POLL) begin miscompares++; $display("FAIL restart_delay: got %0d want %0d", rise_cyc - rel_cyc, POLL); end
        wait_valid(SLOT * 30, ok);
        vectors++; if (data !== 16'h0020) begin miscompares++; $display("FAIL restart_data: got %h want 0020", data); end
        wait_busy_fall(SLOT * 4, ok);
    endtask

    task automatic test_bus_legality();
        vectors++; if (bus_err != 0) begin miscompares++; $display("FAIL sda_while_scl_high: got %0d illegal edges want 0", bus_err); end
        vectors++; if (low_bad != 0) begin miscompares++; $display("FAIL scl_low_time: got %0d bad periods want 0", low_bad); end
        vectors++; if (high_bad != 0) begin miscompares++; $display("FAIL scl_high_time: got %0d bad periods want 0", high_bad); end
        vectors++; if (idle_bad != 0) begin miscompares++; $display("FAIL idle_bus: got %0d bad cycles want 0", idle_bad); end
        vectors++; if (start_cnt != 7) begin miscompares++; $display("FAIL start_count: got %0d want 7", start_cnt); end
        vectors++; if (stop_cnt != 6) begin miscompares++; $display("FAIL stop_count: got %0d want 6", stop_cnt); end
        vectors++; if (low_seen != 159) begin miscompares++; $display("FAIL scl_low_count: got %0d want 159", low_seen); end
        vectors++; if (high_seen != 153) begin miscompares++; $display("FAIL scl_high_count: got %0d want 153", high_seen); end
    endtask

    initial begin
        test_reset();
        test_read_25_5();
        test_lsb_mask_sign();
        test_addr_nack();
        test_reset_mid();
        test_bus_legality();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lm75a_i2c_reader.md
# lm75a_i2c_reader

Periodic I2C master that reads the two-byte temperature register of an LM75A sensor and presents it as a 16-bit word. It sits directly upstream of the 7-segment temperature display decoder and drives that block's `data[15:0]` input. Each poll is a current-pointer read: START, address+R, MSB, LSB, STOP. The LM75A pointer powers up at 0x00 (temperature), so no pointer write is issued.

## Interface
- `DEV_ADDR`, 7'h48: 7-bit LM75A slave address (A2..A0 = 000).
- `QDIV`, 125: clk cycles per SCL quarter-period. 50 MHz / (4·125) = 100 kHz SCL.
- `POLL_CYCLES`, 5_000_000: clk cycles between transaction starts (100 ms at 50 MHz). Must exceed 29·4·QDIV.
- `clk` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low. One clock domain only.
- `sda_in` input, 1 bit: SDA pad level, already synchronised externally.
- `sda_oe` output, 1 bit: 1 pulls SDA low; 0 releases it (open-drain). Reset value 0.
- `scl` output, 1 bit: SCL level, push-pull. The LM75A never stretches the clock. Reset value 1.
- `data` output, 16 bits: {MSB, LSB[7:5], 5'b0}. Bit 15 is the sign; bit 7 is the 0.5 °C bit. Reset value 16'h0000.
- `valid` output, 1 bit: one-cycle pulse when `data` updates. Reset value 0.
- `busy` output, 1 bit: high from START slot entry to STOP slot end. Reset value 0.
- `ack_err` output, 1 bit: set on address NACK, cleared on the next successful read. Reset value 0.

## Operation
- Poll counter runs 0..POLL_CYCLES-1 from reset and wraps. On each wrap the FSM leaves IDLE into START.
- The first transaction therefore starts POLL_CYCLES cycles after `rst_n` rises. This gives the LM75A power-up conversion time.
- FSM states: IDLE, START, ADDR (8 bits), AACK, RD_MSB (8), MACK, RD_LSB (8), MNACK, STOP.
- Each state occupies whole bit slots. A bit slot is 4 quarters Q0..Q3, each QDIV cycles long.
- Data slot waveform:
  - SCL = 0 in Q0/Q1 and 1 in Q2/Q3.
  - `sda_oe` changes only on Q0 entry.
  - `sda_in` is sampled on the last cycle of Q2.
- START slot: SCL = 1 throughout. SDA is released in Q0/Q1 and pulled low from Q2 entry.
- STOP slot:
  - SDA low in Q0–Q2.
  - SCL = 0 in Q0/Q1 and 1 in Q2/Q3.
  - SDA is released on Q3 entry.
- ADDR: sends {DEV_ADDR, 1'b1} MSB first, i.e. 0x91 for the default address.
- AACK: SDA released.
  - Sampled 0: continue to RD_MSB.
  - Sampled 1: set `ack_err` and go directly to STOP. `data` is unchanged and no `valid` pulse is issued.
- RD_MSB and RD_LSB: SDA released; bits shift in MSB first.
- MACK: master drives SDA low.
- MNACK: master releases SDA.
- After the MNACK slot, on the same clock:
  - `data` loads {MSB, LSB[7:5], 5'b0}.
  - `valid` pulses.
  - `ack_err` clears.
- Both bytes update atomically; no intermediate half-updated value is ever visible.
- A poll wrap while `busy` = 1 is ignored, not queued. This cannot occur with legal parameters.
- Asynchronous reset mid-transaction forces every output to its reset value immediately: SDA released, SCL high.
  - The partial transaction is discarded.
  - The poll counter restarts from 0.
- Negative temperatures pass through raw; the downstream stage handles the sign.

## Timing
- Full transaction: 29 bit slots = 116·QDIV clk cycles, i.e. 14 500 cycles / 290 µs by default.
- `valid` is asserted exactly 28·4·QDIV cycles after START slot entry. It is high for exactly one cycle.
- `busy` drops on the cycle after the STOP slot Q3 ends. The FSM returns to IDLE on that cycle.
- `data` is registered and holds its value between updates.

## Test plan
- Read 25.5 °C (QDIV=2, POLL_CYCLES=400), slave ACKs address and returns 0x19, 0x80:
  - Bus address byte observed is 0x91.
  - Master ACK after MSB, NACK after LSB.
  - `data` = 16'h1980 with a single `valid` pulse; `ack_err` = 0.
- LSB masking and sign, slave returns 0x7D, 0xFF, then 0xE7, 0x00 on the next poll:
  - `data` = 16'h7DE0, then 16'hE700.
  - Exactly two `valid` pulses, one per poll.
- Address NACK, slave leaves SDA high at AACK:
  - `ack_err` = 1; `data` keeps its previous value; no `valid` pulse.
  - STOP is generated, then the next poll retries.
  - When the retry succeeds, `ack_err` returns to 0.
- Poll spacing:
  - START slot entries occur exactly POLL_CYCLES apart.
  - The first START is POLL_CYCLES cycles after reset release.
  - SCL stays high and `sda_oe` stays 0 while idle.
- Reset asserted during RD_MSB:
  - Immediately `scl` = 1, `sda_oe` = 0, `busy` = 0, `data` = 0, `valid` = 0.
  - After release, the next START occurs POLL_CYCLES cycles later.
- START/STOP legality, checked by a bus monitor:
  - SDA changes while SCL is high only at the START falling edge and the STOP rising edge.
  - SCL high and low times are each exactly 2·QDIV cycles.
